stepper_seq_driver: RTL and testbench

- Parametrised next-generation H-bridge stepper sequencer: accepts move commands (step count, direction, step mode, step period) over a valid/ready handshake and drives the 4-bit bridge pattern.
- Adds programmable step rate, half-step mode, persistent phase across moves, a signed position tracker, abort, and a selectable idle hold/coast output.
- Sits between the fabric/MSS command registers and the bridge pins; one instance per motor.

---
 rtl/stepper_pkg.sv | 30 +++
 rtl/stepper_seq_driver_step_timer.sv | 39 +++
 rtl/stepper_seq_driver.sv | 144 ++++++++++++++
 tb/tb_stepper_seq_driver.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared types, phase table and step-delta helper for the stepper sequencer.
package stepper_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Forward-order bridge patterns; entry 0 is the least significant nibble.
  // Even indices are the full-step (two-coil) patterns.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1000, 4'b1010, 4'b0010, 4'b0110,
    4'b0100, 4'b0101, 4'b0001, 4'b1001
  };

  localparam logic [3:0] COAST = 4'b0000;

  // Signed phase increment for one step. Full-step from an odd (half-step)
  // index moves by one so the motor lands back on a full-step phase.
  function automatic logic signed [2:0] phase_delta(
    input logic dir,
    input logic half,
    input logic odd
  );
    logic signed [2:0] mag;
    mag = (half || odd) ? 3'sd1 : 3'sd2;
    return dir ? mag : -mag;
  endfunction

endpackage

// File: rtl/stepper_seq_driver_step_timer.sv
// Step-rate timer: loads a period, counts down while running and pulses
// expire on the cycle a step is due, reloading itself for the next step.
module step_timer #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PER_W-1:0] period,
  input  logic             run,
  output logic             expire
);

  logic [PER_W-1:0] per_q;
  logic [PER_W-1:0] cnt;

  assign expire = run && (cnt == PER_W'(1));

  // Down-counter: load on command accept, reload on expiry, else decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= period;
    end else if (expire) begin
      cnt <= per_q;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - PER_W'(1);
    end
  end

  // Hold the period of the current move for reloads (caller guarantees >= 1).
  always_ff @(posedge clk) begin
    if (load) begin
      per_q <= period;
    end
  end

endmodule

// File: rtl/stepper_seq_driver.sv
// H-bridge stepper sequencer: accepts move commands, steps the phase table
// at a programmable rate, tracks signed position and supports abort.
import stepper_pkg::*;

module stepper_seq_driver #(
  parameter int CNT_W = 32,
  parameter int POS_W = 32,
  parameter int PER_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CNT_W-1:0]        cmd_count,
  input  logic                    cmd_dir,
  input  logic                    cmd_half,
  input  logic [PER_W-1:0]        cmd_period,
  input  logic                    abort,
  input  logic                    idle_hold,
  output logic [3:0]              hb_state,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [CNT_W-1:0]        remaining,
  output logic signed [POS_W-1:0] position
);

  state_t                  state;
  state_t                  state_n;
  logic [2:0]              phase;
  logic [2:0]              phase_n;
  logic [3:0]              hb_n;
  logic signed [POS_W-1:0] pos_n;
  logic signed [POS_W-1:0] pos_step;
  logic [CNT_W-1:0]        rem_n;
  logic                    done_n;
  logic                    aborted_n;
  logic                    dir_q;
  logic                    half_q;
  logic                    accept;
  logic                    tmr_load;
  logic                    tmr_expire;
  logic signed [2:0]       delta;
  logic [PER_W-1:0]        eff_period;

  assign cmd_ready  = (state == IDLE) && !rst;
  assign accept     = cmd_valid && cmd_ready;
  assign busy       = (state == RUN);
  assign eff_period = (cmd_period == '0) ? PER_W'(1) : cmd_period;

  step_timer #(
    .PER_W(PER_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .period (eff_period),
    .run    (busy),
    .expire (tmr_expire)
  );

  // Next-state, step arithmetic and next bridge pattern.
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    pos_n     = position;
    rem_n     = remaining;
    done_n    = 1'b0;
    aborted_n = aborted;
    tmr_load  = 1'b0;
    hb_n      = COAST;
    delta     = phase_delta(dir_q, half_q, phase[0]);
    pos_step  = {{(POS_W-3){delta[2]}}, delta};

    case (state)
      IDLE: begin
        if (accept) begin
          tmr_load  = 1'b1;
          rem_n     = cmd_count;
          aborted_n = 1'b0;
          if (cmd_count != '0) begin
            state_n = RUN;
          end else begin
            done_n = 1'b1;
          end
        end
        hb_n = idle_hold ? PHASE_TABLE[phase] : COAST;
      end
      RUN: begin
        // The final step wins over a coincident abort.
        if (tmr_expire && (remaining == CNT_W'(1))) begin
          phase_n = phase + $unsigned(delta);
          pos_n   = position + pos_step;
          rem_n   = '0;
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (abort) begin
          rem_n     = '0;
          state_n   = IDLE;
          done_n    = 1'b1;
          aborted_n = 1'b1;
        end else if (tmr_expire) begin
          phase_n = phase + $unsigned(delta);
          pos_n   = position + pos_step;
          rem_n   = (remaining != '0) ? remaining - CNT_W'(1) : '0;
        end
        hb_n = PHASE_TABLE[phase_n];
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Control and output state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= 3'd0;
      hb_state  <= COAST;
      position  <= '0;
      remaining <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      hb_state  <= hb_n;
      position  <= pos_n;
      remaining <= rem_n;
      done      <= done_n;
      aborted   <= aborted_n;
    end
  end

  // Move parameters captured at the accept edge only.
  always_ff @(posedge clk) begin
    if (accept) begin
      dir_q  <= cmd_dir;
      half_q <= cmd_half;
    end
  end

endmodule

// File: tb/tb_stepper_seq_driver.sv
// Scoreboard bench for stepper_seq_driver: a behavioural model queues the
// expected step and done events, a monitor pops and compares them.
module tb_stepper_seq_driver;

  localparam int CNT_W = 32;
  localparam int POS_W = 32;
  localparam int PER_W = 16;

  localparam logic [3:0] TBL [8] = '{4'b1001, 4'b0001, 4'b0101, 4'b0100,
                                     4'b0110, 4'b0010, 4'b1010, 4'b1000};

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    cmd_valid = 1'b0;
  logic                    cmd_ready;
  logic [CNT_W-1:0]        cmd_count = '0;
  logic                    cmd_dir = 1'b0;
  logic                    cmd_half = 1'b0;
  logic [PER_W-1:0]        cmd_period = '0;
  logic                    abort = 1'b0;
  logic                    idle_hold = 1'b1;
  logic [3:0]              hb_state;
  logic                    busy;
  logic                    done;
  logic                    aborted;
  logic [CNT_W-1:0]        remaining;
  logic signed [POS_W-1:0] position;

  stepper_seq_driver #(.CNT_W(CNT_W), .POS_W(POS_W), .PER_W(PER_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .cmd_dir(cmd_dir), .cmd_half(cmd_half),
    .cmd_period(cmd_period), .abort(abort), .idle_hold(idle_hold),
    .hb_state(hb_state), .busy(busy), .done(done), .aborted(aborted),
    .remaining(remaining), .position(position)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_seen = 1'b1;
  always @(posedge clk) rst_seen <= rst;

  typedef struct {
    int                t;
    logic [3:0]        hb;
    logic signed [31:0] pos;
    logic [31:0]       rem;
  } step_t;

  typedef struct {
    int                t;
    logic              ab;
    logic signed [31:0] pos;
  } done_t;

  step_t step_q[$];
  done_t done_q[$];

  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b1;

  int                 m_phase = 0;
  logic signed [31:0] m_pos = '0;
  logic               m_ab = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=event required=none", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare whenever the DUT takes a step or pulses done.
  initial begin
    logic signed [31:0] prev_pos;
    step_t s;
    done_t d;
    prev_pos = '0;
    forever begin
      @(negedge clk);
      if (rst_seen || !mon_on) begin
        prev_pos = position;
      end else begin
        if (position !== prev_pos) begin
          if (step_q.size() == 0) begin
            flag("unexpected_step");
          end else begin
            s = step_q.pop_front();
            chk("step_time", 64'(cyc), 64'(s.t));
            chk("step_hb", 64'(hb_state), 64'(s.hb));
            chk("step_pos", 64'(position), 64'(s.pos));
            chk("step_rem", 64'(remaining), 64'(s.rem));
          end
          prev_pos = position;
        end
        if (done === 1'b1) begin
          if (done_q.size() == 0) begin
            flag("unexpected_done");
          end else begin
            d = done_q.pop_front();
            chk("done_time", 64'(cyc), 64'(d.t));
            chk("done_aborted", 64'(aborted), 64'(d.ab));
            chk("done_pos", 64'(position), 64'(d.pos));
            chk("done_rem", 64'(remaining), 64'(0));
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (cmd_ready !== 1'b1) flag("ready_timeout");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((step_q.size() != 0 || done_q.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    if (step_q.size() != 0 || done_q.size() != 0) begin
      flag("drain_timeout");
      step_q.delete();
      done_q.delete();
    end
  endtask

  // Reference model of one move: which steps land on which edge, then done.
  task automatic model_move(input int n0, input int cnt, input bit dir, input bit half,
                            input int p, input int ab_off);
    int    e_edge;
    bit    ab_hit;
    int    d;
    step_t s;
    done_t dn;
    e_edge = (ab_off > 0) ? n0 + ab_off : 0;
    ab_hit = (cnt > 0) && (ab_off > 0) && (e_edge < n0 + cnt * p);
    m_ab = 1'b0;
    if (cnt == 0) begin
      dn.t = n0; dn.ab = 1'b0; dn.pos = m_pos;
      done_q.push_back(dn);
      return;
    end
    for (int k = 1; k <= cnt; k++) begin
      if (ab_hit && (n0 + k * p >= e_edge)) break;
      d = (half || (m_phase % 2 == 1)) ? 1 : 2;
      if (!dir) d = -d;
      m_phase = (m_phase + d + 8) % 8;
      m_pos = m_pos + d;
      s.t = n0 + k * p; s.hb = TBL[m_phase]; s.pos = m_pos; s.rem = 32'(cnt - k);
      step_q.push_back(s);
    end
    if (ab_hit) begin
      m_ab = 1'b1;
      dn.t = e_edge; dn.ab = 1'b1; dn.pos = m_pos;
    end else begin
      dn.t = n0 + cnt * p; dn.ab = 1'b0; dn.pos = m_pos;
    end
    done_q.push_back(dn);
  endtask

  // Issue one command; ab_off>0 raises abort so it is sampled at edge N+ab_off;
  // ab_idle raises abort together with cmd_valid at the accept edge.
  task automatic issue(input int cnt, input bit dir, input bit half, input int per,
                       input int ab_off, input bit ab_idle);
    int n0;
    int p;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_count = 32'(cnt);
    cmd_dir = dir;
    cmd_half = half;
    cmd_period = 16'(per);
    abort = ab_idle;
    tick();
    n0 = cyc;
    cmd_valid = 1'b0;
    abort = 1'b0;
    cmd_dir = ~dir;
    cmd_half = ~half;
    p = (per == 0) ? 1 : per;
    model_move(n0, cnt, dir, half, p, (cnt == 0) ? 0 : ab_off);
    if (cnt != 0 && ab_off > 0) begin
      while (cyc < n0 + ab_off - 1) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    drain();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("ready_in_rst", 64'(cmd_ready), 64'(0));
    tick();
    chk("rst_hb", 64'(hb_state), 64'(0));
    chk("rst_pos", 64'(position), 64'(0));
    chk("rst_rem", 64'(remaining), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_aborted", 64'(aborted), 64'(0));
    step_q.delete();
    done_q.delete();
    m_phase = 0;
    m_pos = '0;
    m_ab = 1'b0;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] hb_before;
    int n0;
    int cnt;
    int per;
    int p;
    int ab;
    done_t dn;

    tick();
    tick();
    do_reset();

    // Full-step forward, count 4, period 3.
    idle_hold = 1'b1;
    issue(4, 1'b1, 1'b0, 3, 0, 1'b0);
    chk("t1_pos", 64'(position), 64'(8));
    chk("t1_hb", 64'(hb_state), 64'(4'b1001));

    // Half-step reverse from phase 0.
    do_reset();
    issue(3, 1'b0, 1'b1, 1, 0, 1'b0);
    chk("t2_pos", 64'(position), 64'(-3));
    chk("t2_rem", 64'(remaining), 64'(0));

    // Odd phase realignment, then idle hold/coast.
    do_reset();
    issue(1, 1'b1, 1'b1, 1, 0, 1'b0);
    issue(2, 1'b1, 1'b0, 2, 0, 1'b0);
    chk("t3_pos", 64'(position), 64'(m_pos));
    chk("t3_hb", 64'(hb_state), 64'(4'b0110));
    idle_hold = 1'b0;
    tick();
    chk("coast_hb", 64'(hb_state), 64'(4'b0000));
    idle_hold = 1'b1;
    tick();
    chk("hold_hb", 64'(hb_state), 64'(4'b0110));

    // Abort after the 7th step of a 20-step move.
    issue(20, 1'b1, 1'b0, 5, 36, 1'b0);
    chk("abort_flag", 64'(aborted), 64'(1));
    chk("abort_rem", 64'(remaining), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));

    // Zero-count command with period 0: done next cycle, no motion.
    wait_ready();
    hb_before = hb_state;
    cmd_valid = 1'b1;
    cmd_count = '0;
    cmd_period = '0;
    tick();
    n0 = cyc;
    cmd_valid = 1'b0;
    m_ab = 1'b0;
    dn.t = n0; dn.ab = 1'b0; dn.pos = m_pos;
    done_q.push_back(dn);
    chk("zero_ready", 64'(cmd_ready), 64'(1));
    chk("zero_done", 64'(done), 64'(1));
    chk("zero_aborted_cleared", 64'(aborted), 64'(0));
    tick();
    chk("zero_done_pulse", 64'(done), 64'(0));
    chk("zero_hb", 64'(hb_state), 64'(hb_before));
    drain();

    // Period 0 behaves as period 1.
    issue(3, 1'b1, 1'b1, 0, 0, 1'b0);
    // Abort in IDLE with a simultaneous command.
    issue(2, 1'b0, 1'b0, 2, 0, 1'b1);
    chk("idle_abort_flag", 64'(aborted), 64'(0));
    // Abort coinciding with the final step.
    issue(2, 1'b1, 1'b1, 4, 8, 1'b0);
    chk("final_abort_flag", 64'(aborted), 64'(0));
    chk("final_abort_pos", 64'(position), 64'(m_pos));

    // Reset mid-move.
    mon_on = 1'b0;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_count = 32'd10;
    cmd_dir = 1'b1;
    cmd_half = 1'b1;
    cmd_period = 16'd2;
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    chk("midmove_busy", 64'(busy), 64'(1));
    do_reset();
    mon_on = 1'b1;

    // Randomized moves.
    for (int i = 0; i < 40; i++) begin
      idle_hold = 1'($urandom_range(0, 1));
      cnt = $urandom_range(0, 6);
      per = $urandom_range(0, 4);
      p = (per == 0) ? 1 : per;
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, cnt * p + 2) : 0;
      issue(cnt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), per, ab, 1'b0);
      chk("rand_aborted", 64'(aborted), 64'(m_ab));
      chk("rand_pos", 64'(position), 64'(m_pos));
    end

    tick();
    chk("step_q_empty", 64'(step_q.size()), 64'(0));
    chk("done_q_empty", 64'(done_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
